// File: rtl/operand_sel_buf.sv
// operand_sel_buf: NUM_IN-way operand source select feeding a 2-entry
// valid/ready buffer (head + skid) in front of the ALU. Out-of-range
// select codes are consumed, flagged with a one-cycle pulse and counted.
module operand_sel_buf #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      NUM_IN    = 3,
  parameter int unsigned      SEL_W     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  output logic [7:0]              err_count
);

  localparam int unsigned CNT_W   = 2;
  localparam int unsigned ERR_W   = 8;
  localparam logic [CNT_W-1:0] CNT_EMPTY = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(2);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  // State
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             sel_err_q, sel_err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  // Datapath / handshake terms
  logic [WIDTH-1:0] sel_data;
  logic             sel_ok;
  logic             accept;
  logic             push;
  logic             pop;
  logic             bad_sel;

  // Source mux; out-of-range codes select nothing (zero) and are never pushed
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (in_sel == SEL_W'(i)) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Handshake decode: flush suppresses the push but not the error accounting
  always_comb begin
    sel_ok  = (32'(in_sel) < NUM_IN);
    accept  = in_valid & in_ready_q;
    push    = accept & sel_ok & ~flush & (count_q != CNT_FULL);
    pop     = (count_q != CNT_EMPTY) & out_ready;
    bad_sel = accept & ~sel_ok;
  end

  // Next-state for storage, occupancy, ready and error tracking
  always_comb begin
    count_d     = count_q;
    head_d      = head_q;
    skid_d      = skid_q;
    in_ready_d  = in_ready_q;
    sel_err_d   = 1'b0;
    err_count_d = err_count_q;

    if (flush) begin
      // Data registers hold so out_data stays stable while empty
      count_d = CNT_EMPTY;
    end else if (push && pop) begin
      // Only reachable with a single entry: head is replaced in place
      head_d = sel_data;
    end else if (push) begin
      if (count_q == CNT_EMPTY) begin
        head_d  = sel_data;
        count_d = CNT_ONE;
      end else begin
        skid_d  = sel_data;
        count_d = CNT_FULL;
      end
    end else if (pop) begin
      if (count_q == CNT_FULL) begin
        head_d = skid_q;
      end
      count_d = count_q - CNT_ONE;
    end

    in_ready_d = (count_d != CNT_FULL);

    if (bad_sel) begin
      sel_err_d = 1'b1;
      if (err_count_q != ERR_MAX) begin
        err_count_d = err_count_q + ERR_W'(1);
      end
    end
  end

  // State registers; in_ready stays low until the first edge after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= CNT_EMPTY;
      head_q      <= RESET_VAL;
      skid_q      <= RESET_VAL;
      in_ready_q  <= 1'b0;
      sel_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      count_q     <= count_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      sel_err_q   <= sel_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_data  = head_q;
  assign out_valid = (count_q != CNT_EMPTY);
  assign in_ready  = in_ready_q;
  assign sel_err   = sel_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_operand_sel_buf.sv
// Bench for operand_sel_buf: directed stimulus with a scoreboard queue of
// expected operands, drained by an independent output monitor.
module tb_operand_sel_buf;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned NUM_IN = 3;
  localparam int unsigned SEL_W  = 2;

  logic                    clk;
  logic                    reset_n;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;
  logic [7:0]              err_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] src[3];

  operand_sel_buf #(
    .WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .RESET_VAL('0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat, holding in_valid until it is accepted (bounded)
  task automatic send(input int sel);
    bit done = 0;
    in_valid = 1'b1;
    in_sel   = SEL_W'(sel);
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        if (sel < 3) exp_q.push_back(src[sel]);
        done = 1;
      end
      step();
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: sel %0d not accepted within 20 cycles", sel);
    end
  endtask

  // Wait for the scoreboard to empty (bounded)
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d operands still expected", exp_q.size());
    end
  endtask

  // Output monitor: every ALU handshake must match the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got 0x%08h with nothing expected", out_data);
        end else begin
          chk("out_data_order", out_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    src[0] = 32'h0000_0100;
    src[1] = 32'hDEAD_BEEF;
    src[2] = 32'h0000_0042;
    in_data   = {src[2], src[1], src[0]};
    in_sel    = '0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    reset_n   = 1'b0;

    // Reset values
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_sel_err", 32'(sel_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    #10 reset_n = 1'b1;
    #1 chk("rdy_before_edge", 32'(in_ready), 32'd0);
    step();
    chk("rdy_after_edge", 32'(in_ready), 32'd1);

    // Basic path: one beat, out_valid high exactly one cycle
    out_ready = 1'b1;
    send(1);
    @(negedge clk);
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_data", out_data, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("basic_valid_drop", 32'(out_valid), 32'd0);
    chk("basic_data_hold", out_data, 32'hDEAD_BEEF);
    step();

    // Backpressure: two entries fill, third waits for release
    out_ready = 1'b0;
    send(0);
    send(2);
    in_valid = 1'b1;
    in_sel   = 2'd1;
    @(negedge clk);
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    chk("bp_head", out_data, 32'h0000_0100);
    step();
    out_ready = 1'b1;
    send(1);
    drain();
    @(negedge clk);
    chk("bp_empty", 32'(out_valid), 32'd0);
    step();

    // Back-to-back push/pop at one entry
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_sel = SEL_W'(i % 3);
      @(negedge clk);
      chk("b2b_ready", 32'(in_ready), 32'd1);
      if (i > 0) chk("b2b_valid", 32'(out_valid), 32'd1);
      exp_q.push_back(src[i % 3]);
      step();
    end
    in_valid = 1'b0;
    drain();
    @(negedge clk);
    chk("b2b_empty", 32'(out_valid), 32'd0);
    step();

    // Flush with full buffer and a valid-select beat pending
    out_ready = 1'b0;
    send(1);
    send(2);
    in_valid = 1'b1;
    in_sel   = 2'd0;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    chk("flush_data_hold", out_data, 32'hDEAD_BEEF);
    chk("flush_err_cnt", 32'(err_count), 32'd0);
    step();

    // Flush coincident with an accepted valid select: dropped, no error
    in_valid = 1'b1;
    in_sel   = 2'd2;
    flush    = 1'b1;
    step();
    @(negedge clk);
    chk("flush_push_drop", 32'(out_valid), 32'd0);
    chk("flush_ok_no_err", 32'(sel_err), 32'd0);
    // Flush coincident with an invalid select: error still recorded
    in_sel = 2'd3;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_bad_pulse", 32'(sel_err), 32'd1);
    chk("flush_bad_count", 32'(err_count), 32'd1);
    step();

    // Invalid select: single pulse then saturation
    out_ready = 1'b1;
    send(3);
    @(negedge clk);
    chk("bad_pulse", 32'(sel_err), 32'd1);
    chk("bad_no_valid", 32'(out_valid), 32'd0);
    chk("bad_count", 32'(err_count), 32'd2);
    @(negedge clk);
    chk("bad_pulse_end", 32'(sel_err), 32'd0);
    step();
    in_valid = 1'b1;
    in_sel   = 2'd3;
    repeat (300) step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bad_saturate", 32'(err_count), 32'd255);
    chk("bad_sat_novalid", 32'(out_valid), 32'd0);
    step();

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(0);
    send(1);
    #3 reset_n = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd0);
    chk("arst_err_count", 32'(err_count), 32'd0);
    step();
    #2 reset_n = 1'b1;
    #1 chk("arst_rdy_pre", 32'(in_ready), 32'd0);
    step();
    chk("arst_rdy_post", 32'(in_ready), 32'd1);
    chk("arst_still_empty", 32'(out_valid), 32'd0);

    // Traffic after reset still works
    out_ready = 1'b1;
    send(2);
    drain();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
